// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core: sequences fetch/decode/execute/memory/writeback.
// Mux selects are Moore-decoded from the state; write enables are qualified by mem_ready/zero/funct3 and forced low during reset.
module multicycle_ctrl #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic [2:0] imm_src,
  output logic       illegal,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,  S_DECODE   = 4'd1,  S_MEMADR   = 4'd2,  S_MEMREAD = 4'd3,
    S_MEMWB    = 4'd4,  S_MEMWRITE = 4'd5,  S_EXECUTER = 4'd6,  S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,  S_BRANCH   = 4'd9,  S_JAL      = 4'd10, S_JALR    = 4'd11,
    S_LUI      = 4'd12, S_AUIPC    = 4'd13, S_ERROR    = 4'd14
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_BRNCH = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  state_t r_state;
  logic   r_illegal;
  logic   w_pc_write, w_ir_write, w_mem_write, w_reg_write, w_taken;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= state_t'(RESET_STATE);
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH:    if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LOAD, OP_STORE: r_state <= S_MEMADR;
            OP_RTYPE:          r_state <= S_EXECUTER;
            OP_IALU:           r_state <= S_EXECUTEI;
            OP_BRNCH:          r_state <= S_BRANCH;
            OP_JAL:            r_state <= S_JAL;
            OP_JALR:           r_state <= S_JALR;
            OP_LUI:            r_state <= S_LUI;
            OP_AUIPC:          r_state <= S_AUIPC;
            default: begin
              r_state   <= S_ERROR;
              r_illegal <= 1'b1;
            end
          endcase
        end
        S_MEMADR:   r_state <= (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  if (mem_ready) r_state <= S_MEMWB;
        S_MEMWRITE: if (mem_ready) r_state <= S_FETCH;
        S_MEMWB, S_ALUWB, S_BRANCH: r_state <= S_FETCH;
        S_EXECUTER, S_EXECUTEI, S_JAL, S_LUI, S_AUIPC: r_state <= S_ALUWB;
        S_JALR:     r_state <= S_JAL;
        S_ERROR: begin
          r_state   <= S_ERROR;
          r_illegal <= 1'b1;
        end
        default:    r_state <= S_FETCH;
      endcase
    end
  end

  assign w_taken = ((funct3 == 3'b000) & zero) | ((funct3 == 3'b001) & ~zero);

  always_comb begin
    adr_src     = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    w_pc_write  = 1'b0;
    w_ir_write  = 1'b0;
    w_mem_write = 1'b0;
    w_reg_write = 1'b0;
    case (r_state)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        w_ir_write = mem_ready;
        w_pc_write = mem_ready;
      end
      S_DECODE:   begin alu_src_a = 2'b01; alu_src_b = 2'b01; end
      S_MEMADR:   begin alu_src_a = 2'b10; alu_src_b = 2'b01; end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB:    begin result_src = 2'b01; w_reg_write = 1'b1; end
      S_MEMWRITE: begin adr_src = 1'b1; w_mem_write = 1'b1; end
      S_EXECUTER: begin alu_src_a = 2'b10; alu_op = 2'b10; end
      S_EXECUTEI: begin alu_src_a = 2'b10; alu_src_b = 2'b01; alu_op = 2'b10; end
      S_ALUWB:    w_reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b01;
        w_pc_write = w_taken;
      end
      // PC takes the target computed in DECODE/JALR while the ALU forms the link address.
      S_JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        w_pc_write = 1'b1;
      end
      S_JALR:     begin alu_src_a = 2'b10; alu_src_b = 2'b01; end
      S_LUI:      begin alu_src_b = 2'b01; alu_op = 2'b11; end
      S_AUIPC:    begin alu_src_a = 2'b01; alu_src_b = 2'b01; end
      default: ;
    endcase
  end

  always_comb begin
    case (op)
      OP_STORE:        imm_src = 3'b001;
      OP_BRNCH:        imm_src = 3'b010;
      OP_JAL:          imm_src = 3'b011;
      OP_AUIPC, OP_LUI: imm_src = 3'b100;
      default:         imm_src = 3'b000;
    endcase
  end

  // Async reset clears the state at once, but FETCH still qualifies on mem_ready, so gate explicitly.
  assign pc_write  = w_pc_write  & ~reset;
  assign ir_write  = w_ir_write  & ~reset;
  assign mem_write = w_mem_write & ~reset;
  assign reg_write = w_reg_write & ~reset;
  assign illegal   = r_illegal;
  assign state_dbg = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized instruction stream against a path-per-instruction reference model of the control FSM.
module tb_multicycle_ctrl;

  logic       clk, reset, zero, mem_ready;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [2:0] imm_src;
  logic [3:0] state_dbg;

  int n_vec = 0;
  int n_err = 0;
  logic m_illegal;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .imm_src(imm_src), .illegal(illegal), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // {adr_src, result_src, alu_src_a, alu_src_b, alu_op} for each state code
  function automatic logic [8:0] mux_exp(input int st);
    case (st)
      0:  return {1'b0, 2'b10, 2'b00, 2'b10, 2'b00};
      1:  return {1'b0, 2'b00, 2'b01, 2'b01, 2'b00};
      2:  return {1'b0, 2'b00, 2'b10, 2'b01, 2'b00};
      3:  return {1'b1, 2'b00, 2'b00, 2'b00, 2'b00};
      4:  return {1'b0, 2'b01, 2'b00, 2'b00, 2'b00};
      5:  return {1'b1, 2'b00, 2'b00, 2'b00, 2'b00};
      6:  return {1'b0, 2'b00, 2'b10, 2'b00, 2'b10};
      7:  return {1'b0, 2'b00, 2'b10, 2'b01, 2'b10};
      9:  return {1'b0, 2'b00, 2'b10, 2'b00, 2'b01};
      10: return {1'b0, 2'b00, 2'b01, 2'b10, 2'b00};
      11: return {1'b0, 2'b00, 2'b10, 2'b01, 2'b00};
      12: return {1'b0, 2'b00, 2'b00, 2'b01, 2'b11};
      13: return {1'b0, 2'b00, 2'b01, 2'b01, 2'b00};
      default: return 9'd0;
    endcase
  endfunction

  function automatic logic [2:0] imm_exp(input logic [6:0] o);
    if (o == 7'b0100011) return 3'b001;
    if (o == 7'b1100011) return 3'b010;
    if (o == 7'b1101111) return 3'b011;
    if (o == 7'b0010111 || o == 7'b0110111) return 3'b100;
    return 3'b000;
  endfunction

  task automatic check_cycle(input int st, input logic in_rst);
    logic taken;
    logic e_pc, e_ir, e_mw, e_rw;
    taken = (funct3 == 3'd0 && zero) || (funct3 == 3'd1 && !zero);
    e_ir  = !in_rst && st == 0 && mem_ready;
    e_pc  = !in_rst && ((st == 0 && mem_ready) || (st == 9 && taken) || st == 10);
    e_mw  = !in_rst && st == 5;
    e_rw  = !in_rst && (st == 4 || st == 8);
    chk("state_dbg", 32'(state_dbg), 32'(st));
    chk("pc_write",  32'(pc_write),  32'(e_pc));
    chk("ir_write",  32'(ir_write),  32'(e_ir));
    chk("mem_write", 32'(mem_write), 32'(e_mw));
    chk("reg_write", 32'(reg_write), 32'(e_rw));
    chk("mux_sel",   32'({adr_src, result_src, alu_src_a, alu_src_b, alu_op}), 32'(mux_exp(st)));
    chk("imm_src",   32'(imm_src),   32'(imm_exp(op)));
    chk("illegal",   32'(illegal),   32'(m_illegal));
  endtask

  initial begin
    int q[$];
    int idx, cyc, stalls, abort_at, k;
    logic is_illegal, aborted;

    reset = 1'b1; op = 7'd0; funct3 = 3'd0; zero = 1'b0; mem_ready = 1'b1;
    m_illegal = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_cycle(0, 1'b1);

    for (int n = 0; n < 400; n++) begin
      k = $urandom_range(0, 9);
      is_illegal = 1'b0;
      funct3 = 3'($urandom_range(0, 7));
      case (k)
        0: begin op = 7'b0110011; q = '{0, 1, 6, 8}; end
        1: begin op = 7'b0010011; q = '{0, 1, 7, 8}; end
        2: begin op = 7'b0000011; q = '{0, 1, 2, 3, 4}; end
        3: begin op = 7'b0100011; q = '{0, 1, 2, 5}; end
        4: begin op = 7'b1100011; q = '{0, 1, 9}; funct3 = 3'($urandom_range(0, 3)); end
        5: begin op = 7'b1101111; q = '{0, 1, 10, 8}; end
        6: begin op = 7'b1100111; q = '{0, 1, 11, 10, 8}; end
        7: begin op = 7'b0110111; q = '{0, 1, 12, 8}; end
        8: begin op = 7'b0010111; q = '{0, 1, 13, 8}; end
        default: begin
          op = 7'($urandom_range(0, 127)) & 7'h7C;
          is_illegal = 1'b1;
          q = '{0, 1};
          for (int j = 0; j < 20; j++) q.push_back(14);
        end
      endcase
      abort_at = ($urandom_range(0, 11) == 0) ? $urandom_range(0, q.size() + 2) : -1;
      idx = 0; cyc = 0; stalls = 0; aborted = 1'b0;
      while (idx < q.size() && !aborted) begin
        @(negedge clk);
        reset = 1'b0;
        mem_ready = ($urandom_range(0, 3) != 0) || (stalls >= 8);
        zero = 1'($urandom_range(0, 1));
        if (cyc == abort_at) begin
          reset = 1'b1;
          m_illegal = 1'b0;
          #1 check_cycle(0, 1'b1);
          aborted = 1'b1;
        end else begin
          if (q[idx] == 14) m_illegal = 1'b1;
          #1 check_cycle(q[idx], 1'b0);
          if ((q[idx] == 0 || q[idx] == 3 || q[idx] == 5) && !mem_ready) stalls++;
          else idx++;
        end
        cyc++;
      end
      if (is_illegal && !aborted) begin
        @(negedge clk);
        reset = 1'b1;
        mem_ready = 1'b1;
        m_illegal = 1'b0;
        #1 check_cycle(0, 1'b1);
      end
    end

    @(negedge clk);
    reset = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
